// File: rtl/angle_out_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : angle_out_pkg
//  Purpose  : Shared types and angle constants for the angle-scheduled
//             output channel.
//  Contents : channel state enum, 720/360 degree angle tops, ticks per tooth.
//  Revision : 1.0 - initial release
// ============================================================================
package angle_out_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    ARMED    = 2'd1,
    ACTIVE   = 2'd2
  } ch_state_e;

  // 60 teeth x 64 ticks x 2 revolutions, minus 1
  localparam int unsigned ACNT_TOP_720    = 7679;
  localparam int unsigned TICKS_PER_TOOTH = 64;
  localparam int unsigned ACNT_TOP_360    = 3839;

endpackage
`default_nettype wire

// File: rtl/angle_out_channel_match.sv
`default_nettype none
// ============================================================================
//  Module   : angle_match
//  Purpose  : Angle equality compare qualified by the previous angle sample.
//             Fires only on the cycle the counter arrives at the target, so a
//             stalled counter yields one event and a reload straight onto the
//             target (previous sample invalid) yields none.
//  Ports    : i_acnt        current angle
//             i_acnt_prev   angle registered one cycle earlier
//             i_valid       counter valid this cycle
//             i_valid_prev  counter valid previous cycle
//             i_target      compare angle
//             o_match       arrival event
//  Revision : 1.0 - initial release
// ============================================================================
module angle_match
  import angle_out_pkg::*;
#(
  parameter int ACNT_WIDTH = 24
) (
  input  logic [ACNT_WIDTH-1:0] i_acnt,
  input  logic [ACNT_WIDTH-1:0] i_acnt_prev,
  input  logic                  i_valid,
  input  logic                  i_valid_prev,
  input  logic [ACNT_WIDTH-1:0] i_target,
  output logic                  o_match
);

  assign o_match = i_valid & i_valid_prev &
                   (i_acnt == i_target) & (i_acnt_prev != i_target);

endmodule
`default_nettype wire

// File: rtl/angle_out_channel.sv
`default_nettype none
// ============================================================================
//  Module   : angle_out_channel
//  Purpose  : One angle-scheduled output (coil / injector). Drives out high
//             from the set angle to the reset angle of the 720 degree cycle.
//             Angles are double-buffered: writes land in a shadow and are
//             committed while disabled, or on a wrap while armed.
//  Option   : ANGLE_OUT_DWELL_LIMIT_EN - builds the dwell counter, timeout
//             exit and sticky fault flag. Undefined: fault tied low.
//  Ports    : clk, rst (async active-low)
//             acnt_valid, acnt      angle counter input
//             ch_en                 channel enable
//             wr_en, wr_set, wr_reset, wr_ack, wr_err, pending  shadow write
//             out                   channel drive
//             fault, fault_clr      dwell-limit fault
//             fire_cnt              completed activations (wraps)
//  Revision : 1.0 - initial release
// ============================================================================
module angle_out_channel
  import angle_out_pkg::*;
#(
  parameter int                     ACNT_WIDTH  = 24,
  parameter int unsigned            ACNT_TOP    = ACNT_TOP_720,
  parameter int                     DWELL_WIDTH = 24,
  parameter logic [DWELL_WIDTH-1:0] MAX_DWELL   = 24'd1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  acnt_valid,
  input  logic [ACNT_WIDTH-1:0] acnt,
  input  logic                  ch_en,
  input  logic                  wr_en,
  input  logic [ACNT_WIDTH-1:0] wr_set,
  input  logic [ACNT_WIDTH-1:0] wr_reset,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  pending,
  output logic                  out,
  output logic                  fault,
  input  logic                  fault_clr,
  output logic [15:0]           fire_cnt
);

  localparam logic [ACNT_WIDTH-1:0] c_ACNT_TOP = ACNT_WIDTH'(ACNT_TOP);

  ch_state_e             r_state;
  logic [ACNT_WIDTH-1:0] r_set;
  logic [ACNT_WIDTH-1:0] r_reset;
  logic [ACNT_WIDTH-1:0] r_shadow_set;
  logic [ACNT_WIDTH-1:0] r_shadow_reset;
  logic [ACNT_WIDTH-1:0] r_acnt_prev;
  logic                  r_valid_prev;
  logic                  r_pending;
  logic                  r_wr_ack;
  logic                  r_wr_err;
  logic                  r_out;
  logic [15:0]           r_fire_cnt;

  logic w_enable;
  logic w_set_match;
  logic w_reset_match;
  logic w_set_hit;
  logic w_wrap;
  logic w_commit;
  logic w_wr_ok;
  logic w_timeout;

  assign w_enable = acnt_valid & ch_en;

  angle_match #(.ACNT_WIDTH(ACNT_WIDTH)) u_set_match (
    .i_acnt       (acnt),
    .i_acnt_prev  (r_acnt_prev),
    .i_valid      (acnt_valid),
    .i_valid_prev (r_valid_prev),
    .i_target     (r_set),
    .o_match      (w_set_match)
  );

  angle_match #(.ACNT_WIDTH(ACNT_WIDTH)) u_reset_match (
    .i_acnt       (acnt),
    .i_acnt_prev  (r_acnt_prev),
    .i_valid      (acnt_valid),
    .i_valid_prev (r_valid_prev),
    .i_target     (r_reset),
    .o_match      (w_reset_match)
  );

  // A zero-width window (set == reset) never starts a pulse.
  assign w_set_hit = w_set_match & (r_set != r_reset);

  assign w_wrap = acnt_valid & r_valid_prev & (acnt == '0) &
                  (r_acnt_prev == c_ACNT_TOP);

  // No commit in ACTIVE: a pulse spanning the wrap finishes on its old angles
  // and the shadow waits for the next wrap seen while armed.
  assign w_commit = ((r_state == DISABLED) & r_pending) |
                    ((r_state == ARMED) & w_wrap);

  assign w_wr_ok = (wr_set <= c_ACNT_TOP) & (wr_reset <= c_ACNT_TOP);

`ifdef ANGLE_OUT_DWELL_LIMIT_EN
  localparam logic [DWELL_WIDTH-1:0] c_DWELL_LAST = MAX_DWELL - 1'b1;

  logic [DWELL_WIDTH-1:0] r_dwell;
  logic                   r_fault;

  // r_dwell holds (cycles high - 1); hitting the last value makes out fall
  // after exactly MAX_DWELL high cycles.
  assign w_timeout = (r_state == ACTIVE) & w_enable & (r_dwell == c_DWELL_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dwell <= '0;
      r_fault <= 1'b0;
    end else begin
      if (r_state == ACTIVE) begin
        r_dwell <= r_dwell + 1'b1;
      end else begin
        r_dwell <= '0;
      end
      if (w_timeout) begin
        r_fault <= 1'b1;
      end else if (fault_clr) begin
        r_fault <= 1'b0;
      end
    end
  end

  assign fault = r_fault;
`else
  logic w_unused_fault_clr;

  assign w_unused_fault_clr = fault_clr;
  assign w_timeout          = 1'b0;
  assign fault              = 1'b0;
`endif

  // Channel state machine with registered drive and activation counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= DISABLED;
      r_out      <= 1'b0;
      r_fire_cnt <= '0;
    end else if (!w_enable) begin
      r_state <= DISABLED;
      r_out   <= 1'b0;
    end else begin
      case (r_state)
        DISABLED: begin
          r_state <= ARMED;
        end
        ARMED: begin
          if (w_set_hit) begin
            r_state <= ACTIVE;
            r_out   <= 1'b1;
          end
        end
        ACTIVE: begin
          if (w_reset_match | w_timeout) begin
            r_state    <= ARMED;
            r_out      <= 1'b0;
            r_fire_cnt <= r_fire_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= DISABLED;
          r_out   <= 1'b0;
        end
      endcase
    end
  end

  // Angle history, shadow writes and commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acnt_prev    <= '0;
      r_valid_prev   <= 1'b0;
      r_set          <= '0;
      r_reset        <= '0;
      r_shadow_set   <= '0;
      r_shadow_reset <= '0;
      r_pending      <= 1'b0;
      r_wr_ack       <= 1'b0;
      r_wr_err       <= 1'b0;
    end else begin
      r_acnt_prev  <= acnt;
      r_valid_prev <= acnt_valid;
      r_wr_ack     <= wr_en & w_wr_ok;
      r_wr_err     <= wr_en & ~w_wr_ok;

      // Commit reads the shadow before a coincident write replaces it.
      if (w_commit) begin
        r_set   <= r_shadow_set;
        r_reset <= r_shadow_reset;
      end

      if (wr_en & w_wr_ok) begin
        r_shadow_set   <= wr_set;
        r_shadow_reset <= wr_reset;
        r_pending      <= 1'b1;
      end else if (w_commit) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign wr_ack   = r_wr_ack;
  assign wr_err   = r_wr_err;
  assign pending  = r_pending;
  assign out      = r_out;
  assign fire_cnt = r_fire_cnt;

endmodule
`default_nettype wire

// File: doc/angle_out_channel.md
# angle_out_channel

One angle-scheduled output channel (ignition coil or injector driver), downstream of the two-revolution slave angle counter. The channel asserts `out` when the angle counter first reaches a programmed set angle and deasserts it at a programmed reset angle. Angles are double-buffered, so software writes take effect only at a safe point. A hardware dwell limit is included as a compile-time option. Four instances replace the fixed set/reset comparators on the ignition outputs.

## Interface
- `ACNT_WIDTH`, default 24: width of the angle counter and of the angle registers.
- `ACNT_TOP`, default 7679: last angle of the 720° cycle (60 teeth × 64 ticks × 2 revolutions, minus 1).
- `DWELL_WIDTH`, default 24: width of the dwell-limit counter.
- `MAX_DWELL`, default 24'd1000000: maximum cycles `out` may stay high.
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `acnt_valid` in 1: angle counter synchronised (generator running).
- `acnt` in ACNT_WIDTH: current angle, 0..ACNT_TOP; steps by at most +1 per cycle, may stall, wraps to 0.
- `ch_en` in 1: channel enable.
- `wr_en` in 1: single-cycle write strobe for the shadow angles.
- `wr_set` in ACNT_WIDTH: new set angle.
- `wr_reset` in ACNT_WIDTH: new reset angle.
- `wr_ack` out 1: pulse, write accepted.
- `wr_err` out 1: pulse, write rejected.
- `pending` out 1: shadow holds uncommitted angles.
- `out` out 1: channel drive.
- `fault` out 1: sticky dwell-limit fault.
- `fault_clr` in 1: clears `fault`.
- `fire_cnt` out 16: number of completed activations; wraps.

## Operation
- States: DISABLED, ARMED, ACTIVE.
- DISABLED→ARMED when `acnt_valid & ch_en`.
- ARMED→ACTIVE on a set match.
- ACTIVE→ARMED on a reset match or on dwell timeout.
- Any state→DISABLED when `acnt_valid` or `ch_en` is low. `out` drops in the same transition.
- Match definition: `acnt == target`, `acnt_valid` high this cycle and the previous cycle, and the registered previous `acnt != target`.
  - A stalled counter therefore produces exactly one event.
  - A counter reload that lands exactly on the target does not fire.
- Wrap event: `acnt == 0` with previous `acnt == ACNT_TOP`.
- Write handling:
  - A write with `wr_set > ACNT_TOP` or `wr_reset > ACNT_TOP` is rejected: `wr_err` pulses and the shadow is unchanged.
  - Otherwise the shadow is loaded, `pending` is set and `wr_ack` pulses. The last write wins.
- Commit (shadow → active angles, `pending` cleared):
  - Every cycle in DISABLED while `pending` is set.
  - On a wrap event while in ARMED.
  - A wrap event during ACTIVE defers the commit to the next wrap in ARMED. A pulse spanning 0 completes on its old angles.
- `set == reset` in the active angles: set matches are ignored and the channel stays ARMED.
- `fire_cnt` increments on every ACTIVE→ARMED transition, including timeout.
- `wr_en` coincident with a commit: the commit uses the old shadow. The new write lands in the shadow and `pending` stays set.
- `fault_clr` coincident with a new fault: the fault wins.

## Timing
- Reset values:
  - `out`, `fault`, `pending`, `wr_ack`, `wr_err` = 0.
  - `fire_cnt` = 0.
  - Active angles and shadow = 0.
  - State = DISABLED.
- `out` is registered. It rises or falls one cycle after the matching `acnt` value is presented.
- `wr_ack` and `wr_err` are asserted in the cycle after `wr_en`. `pending` is updated in the same cycle.
- Dwell timeout: `out` falls on the cycle the dwell counter reaches `MAX_DWELL`, so `out` is high for exactly `MAX_DWELL` cycles. `fault` sets in the same cycle.
- Reset asserted mid-ACTIVE: `out` goes low immediately and asynchronously.

## Configuration
- `ANGLE_OUT_DWELL_LIMIT_EN` defined: the dwell counter (DWELL_WIDTH bits, cleared on entry to ACTIVE) and the timeout path are built, and `fault` is functional.
- `ANGLE_OUT_DWELL_LIMIT_EN` undefined: no dwell counter is built, `fault` is tied to 0, `fault_clr` is ignored, and ACTIVE exits only on a reset match or disable.

## Structure
- Package `angle_out_pkg` holds:
  - The state enum: DISABLED, ARMED, ACTIVE.
  - `ACNT_TOP_720` = 7679.
  - `TICKS_PER_TOOTH` = 64.
  - `ACNT_TOP_360` = 3839.
- Sub-module `angle_match`: equality compare with the previous-value qualifier, used for both set and reset. It is instantiated twice.

## Test plan
- Commit in DISABLED, then sweep: write set=1152, reset=1216 with channel DISABLED, then enable and sweep `acnt` 0→7679 → `out` high for 64 cycles starting 1 cycle after `acnt`=1152, and `fire_cnt`=1.
- Stall on target: stall `acnt` at 1152 for 50 cycles → a single rise, and `out` stays high until 1216.
- Deferred commit: during ACTIVE with set=7600, reset=64, write set=3072, reset=3136 → the current pulse ends at 64, the new angles commit at the following wrap, and the next pulse starts at 3072.
- Rejected write: write set=7680 → `wr_err` pulses, `pending` stays 0, and the shadow is unchanged.
- Disable mid-pulse: drop `acnt_valid` mid-pulse → `out` falls the next cycle and the state goes to DISABLED; drive reset low mid-pulse → `out` falls immediately.
- Dwell limit: with `ANGLE_OUT_DWELL_LIMIT_EN` and `MAX_DWELL`=100, hold `acnt` between set and reset → `out` high exactly 100 cycles, `fault`=1, and `fault_clr` clears it.
